// File: rtl/seg_scan_scheduler.sv
// Digit scan sequencer for the multiplexed seven-segment display: per-digit on-time,
// inter-digit blanking, registered anode drive and a frame-synchronous one-deep sample buffer.
module seg_scan_scheduler #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000,
    parameter int NUM_DIGITS      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_valid,
    input  logic [47:0] data_in,
    output logic        data_ready,
    input  logic [7:0]  digit_mask,
    output logic [2:0]  cuenta,
    output logic [7:0]  AN,
    output logic        blank,
    output logic        frame_start,
    output logic [47:0] data_hold
);

    localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam int BLANK_LAST_I = (BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0;

    localparam logic [CW-1:0] SHOW_LAST   = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_LAST_I);
    localparam logic [2:0]    LAST_DIGIT  = 3'(NUM_DIGITS - 1);
    localparam logic          HAS_BLANK   = (BLANK_TICKS > 0);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    localparam state_t START_STATE = HAS_BLANK ? S_BLANK : S_SHOW;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    cuenta_next;
    logic [7:0]    an_next;
    logic          blank_next;
    logic          fs_next;
    logic          primed, primed_next;

    logic [47:0]   pending;
    logic          pending_full;

    // The first edge after reset only loads the outputs for slot 0 (anode
    // pattern depends on digit_mask) and raises frame_start; no tick is counted.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt + CW'(1);
        cuenta_next = cuenta;
        fs_next     = 1'b0;
        primed_next = 1'b1;

        if (!primed) begin
            cnt_next = cnt;
            fs_next  = 1'b1;
        end else begin
            case (state)
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_next = S_SHOW;
                        cnt_next   = '0;
                    end
                end
                S_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt_next   = '0;
                        state_next = HAS_BLANK ? S_BLANK : S_SHOW;
                        if (cuenta == LAST_DIGIT) begin
                            cuenta_next = 3'd0;
                            fs_next     = 1'b1;
                        end else begin
                            cuenta_next = cuenta + 3'd1;
                        end
                    end
                end
                default: begin
                    state_next = START_STATE;
                    cnt_next   = '0;
                end
            endcase
        end

        blank_next = (state_next == S_BLANK);
        an_next    = 8'hFF;
        if (state_next == S_SHOW && digit_mask[cuenta_next]) begin
            an_next = ~(8'b1 << cuenta_next);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= START_STATE;
            cnt         <= '0;
            cuenta      <= 3'd0;
            AN          <= 8'hFF;
            blank       <= HAS_BLANK;
            frame_start <= 1'b0;
            primed      <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            cuenta      <= cuenta_next;
            AN          <= an_next;
            blank       <= blank_next;
            frame_start <= fs_next;
            primed      <= primed_next;
        end
    end

    // Transfer has priority; while pending is full data_ready is low, so an
    // accept and a transfer can never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= '0;
            pending_full <= 1'b0;
            data_hold    <= '0;
        end else if (frame_start && pending_full) begin
            data_hold    <= pending;
            pending_full <= 1'b0;
        end else if (data_valid && !pending_full) begin
            pending      <= data_in;
            pending_full <= 1'b1;
        end
    end

    assign data_ready = !pending_full;

endmodule
